control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control_pkg.sv | 166 ++++++++++++++++
 rtl/control_if.sv | 39 +++
 rtl/control.sv | 119 +++++++++++
 tb/tb_control.sv | 106 ++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg -- shared DLX constants for the decode, ALU and memory stages.
//   * opcode / funct field encodings
//   * ALU operation, register-file class and memory access-size encodings
//   * decoded control-word struct and its idle (NOP) value
//   * helpers mapping R-type funct and ALU-immediate opcodes to ALU ops
// ---------------------------------------------------------------------------
package control_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_FPTYPE = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQZ   = 6'h04;
  localparam logic [5:0] OP_BNEZ   = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDUI  = 6'h09;
  localparam logic [5:0] OP_SUBI   = 6'h0A;
  localparam logic [5:0] OP_SUBUI  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LHI    = 6'h0F;
  localparam logic [5:0] OP_JR     = 6'h12;
  localparam logic [5:0] OP_JALR   = 6'h13;
  localparam logic [5:0] OP_SLLI   = 6'h14;
  localparam logic [5:0] OP_SRLI   = 6'h16;
  localparam logic [5:0] OP_SRAI   = 6'h17;
  localparam logic [5:0] OP_SEQI   = 6'h18;
  localparam logic [5:0] OP_SNEI   = 6'h19;
  localparam logic [5:0] OP_SLTI   = 6'h1A;
  localparam logic [5:0] OP_SGTI   = 6'h1B;
  localparam logic [5:0] OP_SLEI   = 6'h1C;
  localparam logic [5:0] OP_SGEI   = 6'h1D;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LF     = 6'h26;
  localparam logic [5:0] OP_LD     = 6'h27;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_SF     = 6'h2E;
  localparam logic [5:0] OP_SD     = 6'h2F;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] F_SLL  = 6'h04;
  localparam logic [5:0] F_SRL  = 6'h06;
  localparam logic [5:0] F_SRA  = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SEQ  = 6'h28;
  localparam logic [5:0] F_SNE  = 6'h29;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SGT  = 6'h2B;
  localparam logic [5:0] F_SLE  = 6'h2C;
  localparam logic [5:0] F_SGE  = 6'h2D;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR  = 4'h3,
    ALU_XOR = 4'h4, ALU_SLL = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7,
    ALU_SEQ = 4'h8, ALU_SNE = 4'h9, ALU_SLT = 4'hA, ALU_SGT = 4'hB,
    ALU_SLE = 4'hC, ALU_SGE = 4'hD, ALU_LHI = 4'hE, ALU_PASSA = 4'hF
  } alu_e;

  typedef enum logic [1:0] {
    FP_INT = 2'b00, FP_SINGLE = 2'b01, FP_DOUBLE = 2'b10
  } fpoint_e;

  typedef enum logic [1:0] {
    DS_BYTE = 2'b00, DS_HALF = 2'b01, DS_WORD = 2'b10, DS_DOUBLE = 2'b11
  } dsize_e;

  typedef struct packed {
    logic    valid;
    alu_e    op;
  } alu_sel_t;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       mem2reg;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    alu_e       aluctrl;
    logic       extop;
    fpoint_e    fpoint;
    logic [4:0] rd;
    dsize_e     dsize;
    logic       loadext;
    logic       jal;
    logic       jar;
  } ctrl_t;

  // Idle control word; rd is overwritten with the instruction field by the decoder.
  localparam ctrl_t CTRL_IDLE = '{
    regdst: 1'b0, alusrc: 1'b0, mem2reg: 1'b0, regwrite: 1'b0,
    memwrite: 1'b0, branch: 1'b0, jump: 1'b0, aluctrl: ALU_ADD,
    extop: 1'b1, fpoint: FP_INT, rd: 5'd0, dsize: DS_WORD,
    loadext: 1'b0, jal: 1'b0, jar: 1'b0
  };

  // R-type / FP R-type funct -> ALU op; valid=0 for unassigned codes.
  function automatic alu_sel_t funct_to_alu(input logic [5:0] funct);
    alu_sel_t s;
    s.valid = 1'b1;
    s.op    = ALU_ADD;
    case (funct)
      F_SLL:          s.op = ALU_SLL;
      F_SRL:          s.op = ALU_SRL;
      F_SRA:          s.op = ALU_SRA;
      F_ADD, F_ADDU:  s.op = ALU_ADD;
      F_SUB, F_SUBU:  s.op = ALU_SUB;
      F_AND:          s.op = ALU_AND;
      F_OR:           s.op = ALU_OR;
      F_XOR:          s.op = ALU_XOR;
      F_SEQ:          s.op = ALU_SEQ;
      F_SNE:          s.op = ALU_SNE;
      F_SLT:          s.op = ALU_SLT;
      F_SGT:          s.op = ALU_SGT;
      F_SLE:          s.op = ALU_SLE;
      F_SGE:          s.op = ALU_SGE;
      default:        s.valid = 1'b0;
    endcase
    return s;
  endfunction

  // ALU-immediate opcode -> ALU op; valid=0 for any other opcode.
  function automatic alu_sel_t imm_to_alu(input logic [5:0] opcode);
    alu_sel_t s;
    s.valid = 1'b1;
    s.op    = ALU_ADD;
    case (opcode)
      OP_ADDI, OP_ADDUI: s.op = ALU_ADD;
      OP_SUBI, OP_SUBUI: s.op = ALU_SUB;
      OP_ANDI:           s.op = ALU_AND;
      OP_ORI:            s.op = ALU_OR;
      OP_XORI:           s.op = ALU_XOR;
      OP_LHI:            s.op = ALU_LHI;
      OP_SLLI:           s.op = ALU_SLL;
      OP_SRLI:           s.op = ALU_SRL;
      OP_SRAI:           s.op = ALU_SRA;
      OP_SEQI:           s.op = ALU_SEQ;
      OP_SNEI:           s.op = ALU_SNE;
      OP_SLTI:           s.op = ALU_SLT;
      OP_SGTI:           s.op = ALU_SGT;
      OP_SLEI:           s.op = ALU_SLE;
      OP_SGEI:           s.op = ALU_SGE;
      default:           s.valid = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_if.sv
// ---------------------------------------------------------------------------
// control_if -- instruction word in, decoded control signals out.
//   master : fetch/decode side, drives instruction, observes controls
//   slave  : the control decoder
// ---------------------------------------------------------------------------
interface control_if;
  import control_pkg::*;

  logic [31:0] instruction;
  logic        regdst;
  logic        alusrc;
  logic        mem2reg;
  logic        regwrite;
  logic        memwrite;
  logic        branch;
  logic        jump;
  alu_e        aluctrl;
  logic        extop;
  fpoint_e     fpoint;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  dsize_e      dsize;
  logic        loadext;
  logic        jal;
  logic        jar;

  modport master (
    output instruction,
    input  regdst, alusrc, mem2reg, regwrite, memwrite, branch, jump,
           aluctrl, extop, fpoint, rd, rs1, rs2, dsize, loadext, jal, jar
  );

  modport slave (
    input  instruction,
    output regdst, alusrc, mem2reg, regwrite, memwrite, branch, jump,
           aluctrl, extop, fpoint, rd, rs1, rs2, dsize, loadext, jal, jar
  );
endinterface

// File: rtl/control.sv
// ---------------------------------------------------------------------------
// control -- purely combinational DLX main decoder.
//   clk, rst : present for a uniform pipeline-stage port list; no state here,
//              so outputs follow the instruction with zero latency.
//   bus      : control_if.slave; instruction in, all control fields out.
// Unrecognised opcodes/functs decode to the idle (NOP) control word.
// ---------------------------------------------------------------------------
module control
  import control_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  control_if.slave  bus
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  alu_sel_t   w_rsel;
  alu_sel_t   w_isel;
  ctrl_t      w_ctl;
  logic       w_unused;

  assign w_opcode = bus.instruction[31:26];
  assign w_funct  = bus.instruction[5:0];
  assign w_rsel   = funct_to_alu(w_funct);
  assign w_isel   = imm_to_alu(w_opcode);

  // Shift-amount bits and the stage clock/reset are not needed by the decoder.
  assign w_unused = &{1'b0, clk, rst, bus.instruction[10:6]};

  always_comb begin
    w_ctl    = CTRL_IDLE;
    w_ctl.rd = bus.instruction[15:11];
    case (w_opcode)
      OP_RTYPE, OP_FPTYPE: begin
        if (w_rsel.valid) begin
          w_ctl.regdst   = 1'b1;
          w_ctl.regwrite = 1'b1;
          w_ctl.aluctrl  = w_rsel.op;
          // FP variants select the double file via funct bit 0.
          if (w_opcode == OP_FPTYPE)
            w_ctl.fpoint = w_funct[0] ? FP_DOUBLE : FP_SINGLE;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LF, OP_LD: begin
        w_ctl.alusrc   = 1'b1;
        w_ctl.mem2reg  = 1'b1;
        w_ctl.regwrite = 1'b1;
        w_ctl.loadext  = !(w_opcode == OP_LBU || w_opcode == OP_LHU);
        case (w_opcode)
          OP_LB, OP_LBU: w_ctl.dsize = DS_BYTE;
          OP_LH, OP_LHU: w_ctl.dsize = DS_HALF;
          OP_LF:         begin w_ctl.dsize = DS_WORD;   w_ctl.fpoint = FP_SINGLE; end
          OP_LD:         begin w_ctl.dsize = DS_DOUBLE; w_ctl.fpoint = FP_DOUBLE; end
          default:       w_ctl.dsize = DS_WORD;
        endcase
      end
      OP_SB, OP_SH, OP_SW, OP_SF, OP_SD: begin
        w_ctl.alusrc   = 1'b1;
        w_ctl.memwrite = 1'b1;
        case (w_opcode)
          OP_SB:   w_ctl.dsize = DS_BYTE;
          OP_SH:   w_ctl.dsize = DS_HALF;
          OP_SF:   begin w_ctl.dsize = DS_WORD;   w_ctl.fpoint = FP_SINGLE; end
          OP_SD:   begin w_ctl.dsize = DS_DOUBLE; w_ctl.fpoint = FP_DOUBLE; end
          default: w_ctl.dsize = DS_WORD;
        endcase
      end
      // The eq/ne sense is taken from instruction[26] by the branch unit.
      OP_BEQZ, OP_BNEZ: w_ctl.branch = 1'b1;
      OP_J:             w_ctl.jump   = 1'b1;
      OP_JAL: begin
        w_ctl.jump     = 1'b1;
        w_ctl.jal      = 1'b1;
        w_ctl.regwrite = 1'b1;
        w_ctl.regdst   = 1'b1;
        w_ctl.rd       = LINK_REG;
      end
      OP_JR:            w_ctl.jar    = 1'b1;
      OP_JALR: begin
        w_ctl.jar      = 1'b1;
        w_ctl.jal      = 1'b1;
        w_ctl.regwrite = 1'b1;
        w_ctl.regdst   = 1'b1;
        w_ctl.rd       = LINK_REG;
      end
      default: begin
        if (w_isel.valid) begin
          w_ctl.alusrc   = 1'b1;
          w_ctl.regwrite = 1'b1;
          w_ctl.aluctrl  = w_isel.op;
          // Unsigned and logical immediates are zero-extended.
          w_ctl.extop    = !(w_opcode == OP_ADDUI || w_opcode == OP_SUBUI ||
                             w_opcode == OP_ANDI  || w_opcode == OP_ORI   ||
                             w_opcode == OP_XORI);
        end
      end
    endcase
  end

  assign bus.regdst   = w_ctl.regdst;
  assign bus.alusrc   = w_ctl.alusrc;
  assign bus.mem2reg  = w_ctl.mem2reg;
  assign bus.regwrite = w_ctl.regwrite;
  assign bus.memwrite = w_ctl.memwrite;
  assign bus.branch   = w_ctl.branch;
  assign bus.jump     = w_ctl.jump;
  assign bus.aluctrl  = w_ctl.aluctrl;
  assign bus.extop    = w_ctl.extop;
  assign bus.fpoint   = w_ctl.fpoint;
  assign bus.rd       = w_ctl.rd;
  assign bus.rs1      = bus.instruction[25:21];
  assign bus.rs2      = bus.instruction[20:16];
  assign bus.dsize    = w_ctl.dsize;
  assign bus.loadext  = w_ctl.loadext;
  assign bus.jal      = w_ctl.jal;
  assign bus.jar      = w_ctl.jar;

endmodule

// File: tb/tb_control.sv
// ---------------------------------------------------------------------------
// tb_control -- directed vectors for the DLX control decoder. Each vector
// packs every output into one word and compares it to a hand-computed value,
// then checks the mutual-exclusion rules on the same word.
// ---------------------------------------------------------------------------
module tb_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  control_if bus ();

  control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Field order: regdst alusrc mem2reg regwrite memwrite branch jump
  //              aluctrl[4] extop fpoint[2] rd[5] rs1[5] rs2[5] dsize[2]
  //              loadext jal jar
  function automatic logic [33:0] ev(
    input logic rdst, input logic asrc, input logic m2r, input logic rw,
    input logic mw, input logic br, input logic jmp, input logic [3:0] alu,
    input logic ext, input logic [1:0] fp, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] ds,
    input logic lext, input logic jl, input logic jr);
    return {rdst, asrc, m2r, rw, mw, br, jmp, alu, ext, fp, rd, rs1, rs2,
            ds, lext, jl, jr};
  endfunction

  function automatic logic [33:0] observed();
    return {bus.regdst, bus.alusrc, bus.mem2reg, bus.regwrite, bus.memwrite,
            bus.branch, bus.jump, 4'(bus.aluctrl), bus.extop, 2'(bus.fpoint),
            bus.rd, bus.rs1, bus.rs2, 2'(bus.dsize), bus.loadext, bus.jal,
            bus.jar};
  endfunction

  task automatic vec(input string tag, input logic [31:0] instr,
                     input logic [33:0] exp);
    logic [33:0] obs;
    logic        rules_ok;
    @(negedge clk);
    bus.instruction = instr;
    #1;
    obs = observed();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s instr=%h observed=%h expected=%h", tag, instr, obs, exp);
    end
    rules_ok = !(bus.memwrite && bus.regwrite) &&
               ($countones({bus.branch, bus.jump, bus.jar}) <= 1);
    n_vec++;
    assert (rules_ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s_excl instr=%h observed=%b expected=1", tag, instr, rules_ok);
    end
    $display("vec %-8s instr=%h outputs=%h", tag, instr, obs);
  endtask

  initial begin
    bus.instruction = 32'h0;
    // Async reset asserted at start: decoder must be unaffected.
    rst = 1'b1;
    vec("zero_rst", 32'h00000000, ev(0,0,0,0,0,0,0,4'h0,1,2'd0,5'd0,5'd0,5'd0,2'd2,0,0,0));
    rst = 1'b0;
    vec("nop",      32'h00000015, ev(0,0,0,0,0,0,0,4'h0,1,2'd0,5'd0,5'd0,5'd0,2'd2,0,0,0));
    vec("add",      32'h00221820, ev(1,0,0,1,0,0,0,4'h0,1,2'd0,5'd3,5'd1,5'd2,2'd2,0,0,0));
    vec("sub",      32'h00221822, ev(1,0,0,1,0,0,0,4'h1,1,2'd0,5'd3,5'd1,5'd2,2'd2,0,0,0));
    vec("sra",      32'h00221807, ev(1,0,0,1,0,0,0,4'h7,1,2'd0,5'd3,5'd1,5'd2,2'd2,0,0,0));
    vec("sge",      32'h0022182D, ev(1,0,0,1,0,0,0,4'hD,1,2'd0,5'd3,5'd1,5'd2,2'd2,0,0,0));
    vec("badfunct", 32'h0022183F, ev(0,0,0,0,0,0,0,4'h0,1,2'd0,5'd3,5'd1,5'd2,2'd2,0,0,0));
    vec("fadd_s",   32'h04221820, ev(1,0,0,1,0,0,0,4'h0,1,2'd1,5'd3,5'd1,5'd2,2'd2,0,0,0));
    vec("fadd_d",   32'h04221821, ev(1,0,0,1,0,0,0,4'h0,1,2'd2,5'd3,5'd1,5'd2,2'd2,0,0,0));
    vec("lbu",      32'h90250008, ev(0,1,1,1,0,0,0,4'h0,1,2'd0,5'd0,5'd1,5'd5,2'd0,0,0,0));
    vec("lh",       32'h84250008, ev(0,1,1,1,0,0,0,4'h0,1,2'd0,5'd0,5'd1,5'd5,2'd1,1,0,0));
    vec("ld",       32'h9C250008, ev(0,1,1,1,0,0,0,4'h0,1,2'd2,5'd0,5'd1,5'd5,2'd3,1,0,0));
    vec("sw",       32'hAC470004, ev(0,1,0,0,1,0,0,4'h0,1,2'd0,5'd0,5'd2,5'd7,2'd2,0,0,0));
    vec("sb",       32'hA0470004, ev(0,1,0,0,1,0,0,4'h0,1,2'd0,5'd0,5'd2,5'd7,2'd0,0,0,0));
    vec("sf",       32'hB8470004, ev(0,1,0,0,1,0,0,4'h0,1,2'd1,5'd0,5'd2,5'd7,2'd2,0,0,0));
    vec("andi",     32'h3025FFFF, ev(0,1,0,1,0,0,0,4'h2,0,2'd0,5'd31,5'd1,5'd5,2'd2,0,0,0));
    vec("addi",     32'h20250004, ev(0,1,0,1,0,0,0,4'h0,1,2'd0,5'd0,5'd1,5'd5,2'd2,0,0,0));
    vec("lhi",      32'h3C051234, ev(0,1,0,1,0,0,0,4'hE,1,2'd0,5'd2,5'd0,5'd5,2'd2,0,0,0));
    vec("slti",     32'h68250004, ev(0,1,0,1,0,0,0,4'hA,1,2'd0,5'd0,5'd1,5'd5,2'd2,0,0,0));
    vec("beqz",     32'h10200010, ev(0,0,0,0,0,1,0,4'h0,1,2'd0,5'd0,5'd1,5'd0,2'd2,0,0,0));
    vec("bnez",     32'h14200010, ev(0,0,0,0,0,1,0,4'h0,1,2'd0,5'd0,5'd1,5'd0,2'd2,0,0,0));
    vec("j",        32'h08000100, ev(0,0,0,0,0,0,1,4'h0,1,2'd0,5'd0,5'd0,5'd0,2'd2,0,0,0));
    vec("jal",      32'h0C000100, ev(1,0,0,1,0,0,1,4'h0,1,2'd0,5'd31,5'd0,5'd0,2'd2,0,1,0));
    vec("jr",       32'h48800000, ev(0,0,0,0,0,0,0,4'h0,1,2'd0,5'd0,5'd4,5'd0,2'd2,0,0,1));
    vec("jalr",     32'h4C800000, ev(1,0,0,1,0,0,0,4'h0,1,2'd0,5'd31,5'd4,5'd0,2'd2,0,1,1));
    vec("badop3f",  32'hFC000000, ev(0,0,0,0,0,0,0,4'h0,1,2'd0,5'd0,5'd0,5'd0,2'd2,0,0,0));
    vec("badop11",  32'h44000000, ev(0,0,0,0,0,0,0,4'h0,1,2'd0,5'd0,5'd0,5'd0,2'd2,0,0,0));
    // Reset asserted mid-run while an ADD is held: outputs must not move.
    vec("add_pre",  32'h00221820, ev(1,0,0,1,0,0,0,4'h0,1,2'd0,5'd3,5'd1,5'd2,2'd2,0,0,0));
    rst = 1'b1;
    vec("add_rst",  32'h00221820, ev(1,0,0,1,0,0,0,4'h0,1,2'd0,5'd3,5'd1,5'd2,2'd2,0,0,0));
    rst = 1'b0;
    vec("jalr_end", 32'h4C800000, ev(1,0,0,1,0,0,0,4'h0,1,2'd0,5'd31,5'd4,5'd0,2'd2,0,1,1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
